elevator_system: RTL and testbench



---
 rtl/elevator_pkg.sv | 27 ++
 rtl/elevator_timer.sv | 29 ++
 rtl/elevator_system.sv | 115 +++++++++++
 tb/tb_elevator_system.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and sizing helpers for the single-car elevator controller.
// The state codes are visible on the debug port, so their values are fixed.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_e;

    // Floor register width; a two-floor car still needs one bit.
    function automatic int floor_width(input int num_floors);
        return (num_floors > 2) ? $clog2(num_floors) : 1;
    endfunction

    // Dwell/travel counter width: must hold the largest reload value (cycles - 1).
    function automatic int timer_width(input int move_cycles, input int door_cycles,
                                       input int extra_cycles);
        int longest;
        longest = move_cycles;
        if (door_cycles > longest)  longest = door_cycles;
        if (extra_cycles > longest) longest = extra_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter used for both travel time and door dwell.
// Load wins over count-down; the counter parks at zero.
module elevator_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/elevator_system.sv
// Single-car elevator controller: one floor per request, timed door dwell,
// extendable by extra_waiting. Outputs are registered decodes of the next state.
module elevator_system
    import elevator_pkg::*;
#(
    parameter  int NUM_FLOORS   = 8,
    parameter  int MOVE_CYCLES  = 2,
    parameter  int DOOR_CYCLES  = 3,
    parameter  int EXTRA_CYCLES = 4,
    localparam int FLOOR_W      = floor_width(NUM_FLOORS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               move_up,
    input  logic               move_down,
    input  logic               extra_waiting,
    output logic               state_output,
    output logic [FLOOR_W-1:0] current_floor,
    output logic               door_open,
    output logic [1:0]         state
);

    localparam int TIMER_W = timer_width(MOVE_CYCLES, DOOR_CYCLES, EXTRA_CYCLES);

    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [TIMER_W-1:0] MOVE_LOAD  = TIMER_W'(MOVE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD  = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] EXTRA_LOAD = TIMER_W'(EXTRA_CYCLES - 1);

    state_e               state_q;
    state_e               state_next;
    logic [FLOOR_W-1:0]   floor_next;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 timer_en;
    logic                 timer_zero;

    elevator_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state_q;
        floor_next = current_floor;
        timer_load = 1'b0;
        timer_val  = '0;
        timer_en   = 1'b0;

        case (state_q)
            IDLE: begin
                // Up wins over down; requests at the end floors are dropped.
                if (move_up && (current_floor < TOP_FLOOR)) begin
                    state_next = MOVE_UP;
                    timer_load = 1'b1;
                    timer_val  = MOVE_LOAD;
                end else if (move_down && (current_floor != '0)) begin
                    state_next = MOVE_DOWN;
                    timer_load = 1'b1;
                    timer_val  = MOVE_LOAD;
                end
            end

            MOVE_UP, MOVE_DOWN: begin
                if (timer_zero) begin
                    state_next = DOOR_OPEN;
                    timer_load = 1'b1;
                    timer_val  = DOOR_LOAD;
                    floor_next = (state_q == MOVE_UP) ? current_floor + FLOOR_W'(1)
                                                      : current_floor - FLOOR_W'(1);
                end else begin
                    timer_en = 1'b1;
                end
            end

            DOOR_OPEN: begin
                // A held-door press restarts the dwell even on the expiry cycle.
                if (extra_waiting) begin
                    timer_load = 1'b1;
                    timer_val  = EXTRA_LOAD;
                end else if (timer_zero) begin
                    state_next = IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            current_floor <= '0;
            state_output  <= 1'b0;
            door_open     <= 1'b0;
        end else begin
            state_q       <= state_next;
            current_floor <= floor_next;
            state_output  <= (state_next == MOVE_UP) || (state_next == MOVE_DOWN);
            door_open     <= (state_next == DOOR_OPEN);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_elevator_system.sv
// Randomized bench for elevator_system against a phase/remaining-cycles model;
// a default instance and a two-floor, short-timer instance share the stimulus.
module tb_elevator_system;

    typedef struct {
        int floor;
        int phase;   // 0 idle, 1 travelling, 2 door open
        int dir;     // +1 up, -1 down
        int left;    // cycles remaining in the current phase
    } model_t;

    logic       clk;
    logic       reset;
    logic       move_up;
    logic       move_down;
    logic       extra_waiting;

    logic       so_big, door_big;
    logic [2:0] fl_big;
    logic [1:0] st_big;
    logic       so_small, door_small;
    logic [0:0] fl_small;
    logic [1:0] st_small;

    model_t m_big;
    model_t m_small;
    int     n_checks;
    int     n_fail;
    int     so_cnt;
    int     door_cnt;

    elevator_system dut (
        .clk           (clk),
        .reset         (reset),
        .move_up       (move_up),
        .move_down     (move_down),
        .extra_waiting (extra_waiting),
        .state_output  (so_big),
        .current_floor (fl_big),
        .door_open     (door_big),
        .state         (st_big)
    );

    elevator_system #(
        .NUM_FLOORS   (2),
        .MOVE_CYCLES  (1),
        .DOOR_CYCLES  (1),
        .EXTRA_CYCLES (2)
    ) dut_small (
        .clk           (clk),
        .reset         (reset),
        .move_up       (move_up),
        .move_down     (move_down),
        .extra_waiting (extra_waiting),
        .state_output  (so_small),
        .current_floor (fl_small),
        .door_open     (door_small),
        .state         (st_small)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic model_t model_reset();
        model_t r;
        r.floor = 0;
        r.phase = 0;
        r.dir   = 0;
        r.left  = 0;
        return r;
    endfunction

    function automatic model_t model_step(model_t m, bit up, bit dn, bit ex,
                                          int nf, int mc, int dc, int ec);
        model_t r;
        r = m;
        if (m.phase == 0) begin
            if (up && m.floor < nf - 1) begin
                r.phase = 1; r.dir = 1; r.left = mc;
            end else if (dn && m.floor > 0) begin
                r.phase = 1; r.dir = -1; r.left = mc;
            end
        end else if (m.phase == 1) begin
            r.left = m.left - 1;
            if (r.left == 0) begin
                r.floor = m.floor + m.dir;
                r.phase = 2;
                r.left  = dc;
            end
        end else begin
            if (ex) begin
                r.left = ec;
            end else begin
                r.left = m.left - 1;
                if (r.left == 0) r.phase = 0;
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] model_code(model_t m);
        if (m.phase == 1) return (m.dir > 0) ? 2'd1 : 2'd2;
        if (m.phase == 2) return 2'd3;
        return 2'd0;
    endfunction

    task automatic compare_dut(input string who, input model_t m, input logic so,
                               input logic dop, input int fl, input logic [1:0] st);
        check({who, "_moving"}, 32'(so), 32'(m.phase == 1));
        check({who, "_door"},   32'(dop), 32'(m.phase == 2));
        check({who, "_floor"},  32'(fl), 32'(m.floor));
        check({who, "_state"},  32'(st), 32'(model_code(m)));
    endtask

    // Entered at a falling edge: drive, take one rising edge, then check.
    task automatic cycle(input bit up, input bit dn, input bit ex);
        move_up       = up;
        move_down     = dn;
        extra_waiting = ex;
        @(posedge clk);
        m_big   = model_step(m_big,   up, dn, ex, 8, 2, 3, 4);
        m_small = model_step(m_small, up, dn, ex, 2, 1, 1, 2);
        @(negedge clk);
        compare_dut("big",   m_big,   so_big,   door_big,   int'(fl_big),   st_big);
        compare_dut("small", m_small, so_small, door_small, int'(fl_small), st_small);
        if (so_big)   so_cnt++;
        if (door_big) door_cnt++;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && (m_big.phase != 0 || m_small.phase != 0); i++)
            cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        so_cnt        = 0;
        door_cnt      = 0;
        reset         = 1'b1;
        move_up       = 1'b0;
        move_down     = 1'b0;
        extra_waiting = 1'b0;
        m_big         = model_reset();
        m_small       = model_reset();

        @(negedge clk);
        compare_dut("rst_big",   m_big,   so_big,   door_big,   int'(fl_big),   st_big);
        compare_dut("rst_small", m_small, so_small, door_small, int'(fl_small), st_small);
        reset = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);

        // Held up request: second high cycle lands mid-move and must be ignored.
        so_cnt = 0; door_cnt = 0;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        wait_idle();
        check("up_move_len", so_cnt, 2);
        check("up_dwell_len", door_cnt, 3);
        check("up_floor", 32'(fl_big), 1);

        // Down move with one held-door press on the first edge after the door opens.
        so_cnt = 0; door_cnt = 0;
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        wait_idle();
        check("down_move_len", so_cnt, 2);
        check("extra_dwell_len", door_cnt, 5);
        check("down_floor", 32'(fl_big), 0);

        // Two presses: 1 + 2 cycles before the second reload, then 4 more.
        door_cnt = 0;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        wait_idle();
        check("double_extra_dwell_len", door_cnt, 7);

        // Back to floor 0, then a down request there must be dropped.
        cycle(1'b0, 1'b1, 1'b0);
        wait_idle();
        so_cnt = 0;
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("bottom_down_state", 32'(st_big), 0);
        check("bottom_down_moving", so_cnt, 0);

        // Walk to floor 3, then both requests together: up wins.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            wait_idle();
        end
        cycle(1'b1, 1'b1, 1'b0);
        check("both_high_dir", 32'(st_big), 1);
        wait_idle();
        check("both_high_floor", 32'(fl_big), 4);

        // Asynchronous reset in the middle of an up move.
        cycle(1'b1, 1'b0, 1'b0);
        check("pre_reset_moving", 32'(so_big), 1);
        reset = 1'b1;
        #1;
        m_big   = model_reset();
        m_small = model_reset();
        compare_dut("async_rst_big",   m_big,   so_big,   door_big,   int'(fl_big),   st_big);
        compare_dut("async_rst_small", m_small, so_small, door_small, int'(fl_small), st_small);
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);

        // Random traffic, biased upward then downward so both end floors are hit.
        for (int i = 0; i < 800; i++) begin
            int up_pct;
            up_pct = (i < 400) ? 50 : 15;
            cycle($urandom_range(0, 99) < up_pct,
                  $urandom_range(0, 99) < (65 - up_pct),
                  $urandom_range(0, 99) < 20);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
